button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Sequencer that sits between a bank of debounced button inputs and the CPU-visible register file. It turns conditioned button levels into discrete press, release and long-press events. Simultaneous events from several buttons are arbitrated into a single stream and buffered in a small FIFO drained over a valid/ready handshake. An overflow flag reports events lost because they could not be queued.

## Interface
- NUM_BTNS, default 4: number of conditioned button inputs (1..16).
- TICK_DIV, default 50000: clock cycles per hold tick (1 ms at 50 MHz); ≥2.
- LONG_TICKS, default 1000: hold ticks until a long-press event; ≥1.
- FIFO_DEPTH, default 4: event FIFO entries; power of two, ≥2.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- btn_i  in  NUM_BTNS  debounced levels, 1 = pressed; already in the clk domain.
- evt_valid_o  out  1  FIFO head holds an event.
- evt_ready_i  in  1  consumer accepts the head this cycle.
- evt_o  out  2+IDX_W  {type[1:0], index[IDX_W-1:0]}; IDX_W = max(1, clog2(NUM_BTNS)).
- ovf_o  out  1  sticky: one or more events were lost.
- ovf_clr_i  in  1  clears ovf_o.

## Operation
- Event types: PRESS=2'd1, RELEASE=2'd2, LONG=2'd3. Code 0 is never emitted.
- Edge detection: btn_q registers btn_i.
  - rise = btn_i & ~btn_q sets pend_press[i].
  - fall = ~btn_i & btn_q sets pend_rel[i].
- Hold timer:
  - A shared prescaler counts 0..TICK_DIV-1 and pulses tick on the cycle it equals TICK_DIV-1. It free-runs.
  - Per-button hold_cnt is cleared while btn_q[i]=0 and increments on tick while btn_q[i]=1.
  - hold_cnt saturates at LONG_TICKS. Reaching LONG_TICKS sets pend_long[i], once per hold.
- Arbiter, fixed priority:
  - Lowest button index wins.
  - Within a button, PRESS beats LONG beats RELEASE, so per-button event order is preserved.
  - Grants at most one event per cycle, only when the FIFO is not full (a pop in the same cycle does not make room).
  - A grant pushes the event and clears its pending bit.
- Collision: a set condition on a pending bit that is already 1 loses the new event and sets ovf_o. The pending bit stays 1.
  - Exception: clear and set in the same cycle of the same bit is a re-set with no overflow.
- ovf_o: ovf_clr_i clears it. A simultaneous new loss wins, leaving ovf_o=1.
- FIFO: show-ahead. evt_o is valid whenever evt_valid_o=1. Pop occurs when evt_valid_o & evt_ready_i. Push and pop in the same cycle are allowed.
- Reset values: btn_q=0, all pending bits 0, hold_cnt=0, prescaler=0, FIFO empty, evt_valid_o=0, evt_o=0, ovf_o=0.
  - A button held through reset yields a PRESS once rst_n deasserts.
- Mid-operation reset: queued and pending events are discarded. No event is emitted for the reset itself.

## Timing
- btn_i rising, sampled at edge E0: pend_press set at E0, granted in the next cycle, written at E1. evt_valid_o=1 after E1, i.e. 2-edge latency with an empty FIFO and no competing pending events.
- The same 2-edge latency applies to RELEASE. LONG appears 1 edge after the tick edge at which hold_cnt reaches LONG_TICKS.
- Long-press delay from press is between (LONG_TICKS-1)*TICK_DIV+1 and LONG_TICKS*TICK_DIV cycles, because the prescaler is not phase-aligned to the press.
- N simultaneous events drain into the FIFO one per cycle.
- The FIFO sustains one pop per cycle. evt_o changes only after a pop or after a push into an empty FIFO.
- ovf_o rises 1 edge after the colliding cycle.

## Structure
- Package button_evt_pkg holds:
  - the evt_type_t enum (PRESS/RELEASE/LONG);
  - the event-word width function based on IDX_W;
  - the packed evt_t struct {type, index}.
- Sub-module button_evt_fifo: parameterized synchronous show-ahead FIFO with push/pop/full/empty, same clk/rst_n.
- Top level holds edge detect, prescaler, hold counters, pending bits, the priority arbiter and the overflow logic.

## Test plan
- Use TICK_DIV=4, LONG_TICKS=3, NUM_BTNS=4, FIFO_DEPTH=4 throughout.
- Single click: btn_i[2] high for 5 cycles, then low, evt_ready_i=1 -> PRESS{1,2} 2 edges after the rise, RELEASE{2,2} 2 edges after the fall, no LONG, ovf_o=0.
- Long press: btn_i[1] held 20 cycles -> PRESS{1,1}, exactly one LONG{3,1} between cycle 9 and cycle 13 after the press, then RELEASE{2,1} after release.
- Simultaneous: btn_i 4'b0000→4'b1011 in one cycle -> events emitted in order PRESS idx0, idx1, idx3 on consecutive cycles.
- Backpressure/overflow: evt_ready_i=0; btn_i[0] toggled 4 full cycles (8 events) -> FIFO holds 4, pending holds at most 1 PRESS and 1 RELEASE, the remaining presses collide so ovf_o=1. ovf_clr_i pulse -> ovf_o=0. Draining yields the events in order.
- Simultaneous clear and set: ovf_clr_i asserted in the same cycle as a collision -> ovf_o stays 1.
- Reset mid-stream: rst_n=0 for 1 cycle with 3 queued events and btn_i[3] held -> FIFO empties. Afterwards the only event is PRESS{1,3}.

Source files
------------

// File: rtl/button_evt_pkg.sv
// Shared definitions for the button event controller: event codes, the packed
// event record and width helpers.
package button_evt_pkg;

    localparam int MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2,
        EVT_LONG    = 2'd3
    } evt_type_t;

    typedef struct packed {
        evt_type_t              etype;
        logic [MAX_IDX_W-1:0]   index;
    } evt_t;

    function automatic int idx_width(input int num_btns);
        return (num_btns > 1) ? $clog2(num_btns) : 1;
    endfunction

    function automatic int evt_width(input int idx_w);
        return 2 + idx_w;
    endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// Synchronous show-ahead FIFO; the head word is presented combinationally and
// reads as zero while the FIFO is empty.
module button_evt_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG events, arbitrates them
// one per cycle into an event FIFO and flags events lost to collisions.
module button_event_ctrl
    import button_evt_pkg::*;
#(
    parameter int NUM_BTNS   = 4,
    parameter int TICK_DIV   = 50000,
    parameter int LONG_TICKS = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_BTNS-1:0]                           btn_i,
    output logic                                          evt_valid_o,
    input  logic                                          evt_ready_i,
    output logic [evt_width(idx_width(NUM_BTNS))-1:0]     evt_o,
    output logic                                          ovf_o,
    input  logic                                          ovf_clr_i
);

    localparam int IDX_W  = idx_width(NUM_BTNS);
    localparam int EVT_W  = evt_width(IDX_W);
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    logic [NUM_BTNS-1:0] btn_q;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] fall;
    logic [NUM_BTNS-1:0] long_hit;
    logic [PRE_W-1:0]    prescale;
    logic                tick;
    logic [HOLD_W-1:0]   hold_cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0] pend_press, pend_long, pend_rel;
    logic [NUM_BTNS-1:0] clr_press, clr_long, clr_rel;
    logic                grant;
    logic                lost;
    logic                fifo_full;
    logic                fifo_empty;
    evt_t                grant_evt;
    logic [EVT_W-1:0]    grant_word;
    logic                unused_idx;

    assign rise = btn_i & ~btn_q;
    assign fall = ~btn_i & btn_q;
    assign tick = (prescale == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q    <= '0;
            prescale <= '0;
        end else begin
            btn_q    <= btn_i;
            prescale <= tick ? '0 : prescale + 1'b1;
        end
    end

    // Hold counters saturate at LONG_TICKS, so the long hit fires once per hold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (!rst_n || !btn_q[i]) begin
                hold_cnt[i] <= '0;
            end else if (tick && hold_cnt[i] != HOLD_W'(LONG_TICKS)) begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        long_hit = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            long_hit[i] = btn_q[i] & tick & (hold_cnt[i] == HOLD_W'(LONG_TICKS - 1));
        end
    end

    // Lowest index wins; within a button PRESS, then LONG, then RELEASE.
    always_comb begin
        grant           = 1'b0;
        grant_evt.etype = EVT_NONE;
        grant_evt.index = '0;
        clr_press       = '0;
        clr_long        = '0;
        clr_rel         = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (!grant) begin
                    if (pend_press[i]) begin
                        grant           = 1'b1;
                        clr_press[i]    = 1'b1;
                        grant_evt.etype = EVT_PRESS;
                        grant_evt.index = MAX_IDX_W'(i);
                    end else if (pend_long[i]) begin
                        grant           = 1'b1;
                        clr_long[i]     = 1'b1;
                        grant_evt.etype = EVT_LONG;
                        grant_evt.index = MAX_IDX_W'(i);
                    end else if (pend_rel[i]) begin
                        grant           = 1'b1;
                        clr_rel[i]      = 1'b1;
                        grant_evt.etype = EVT_RELEASE;
                        grant_evt.index = MAX_IDX_W'(i);
                    end
                end
            end
        end
    end

    assign grant_word = {grant_evt.etype, grant_evt.index[IDX_W-1:0]};
    assign unused_idx = ^grant_evt.index;

    // A set on a bit that stays pending loses the event; a same-cycle grant makes it a re-set.
    assign lost = |((rise & pend_press & ~clr_press) |
                    (long_hit & pend_long & ~clr_long) |
                    (fall & pend_rel & ~clr_rel));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_press <= '0;
            pend_long  <= '0;
            pend_rel   <= '0;
            ovf_o      <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | rise;
            pend_long  <= (pend_long & ~clr_long) | long_hit;
            pend_rel   <= (pend_rel & ~clr_rel) | fall;
            ovf_o      <= lost | (ovf_o & ~ovf_clr_i);
        end
    end

    button_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (grant_word),
        .pop       (evt_valid_o & evt_ready_i),
        .head      (evt_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_button_event_ctrl;

    localparam int NB = 4;
    localparam int TD = 4;
    localparam int LT = 3;
    localparam int FD = 4;

    logic       clk;
    logic       rst_n;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic       ovf;
    logic [3:0] btn;
    logic [3:0] evt;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] btn;
        logic       rdy;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [18];

    // Reference model state: pending flags per button and kind (0 press, 1 long, 2 release).
    int         m_pre;
    bit   [3:0] m_prev;
    int         m_ticks [4];
    bit         m_pend [4][3];
    bit         m_set [4][3];
    bit         m_clr [4][3];
    bit         m_ovf;
    bit         m_tick;
    bit         m_granted;
    bit         m_loss;
    logic [3:0] m_gevt;
    logic [3:0] m_q [$];

    button_event_ctrl #(
        .NUM_BTNS   (NB),
        .TICK_DIV   (TD),
        .LONG_TICKS (LT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_i       (btn),
        .evt_valid_o (evt_valid),
        .evt_ready_i (evt_ready),
        .evt_o       (evt),
        .ovf_o       (ovf),
        .ovf_clr_i   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [1:0] evtCode(input int t);
        return (t == 0) ? 2'd1 : ((t == 1) ? 2'd3 : 2'd2);
    endfunction

    function automatic logic [5:0] obs();
        return {evt_valid, evt, ovf};
    endfunction

    function automatic logic [5:0] modelOut();
        return (m_q.size() > 0) ? {1'b1, m_q[0], m_ovf} : {1'b0, 4'b0000, m_ovf};
    endfunction

    // Advance the reference model by the clock edge that will sample the current inputs.
    task automatic modelStep();
        if (!rst_n) begin
            m_pre  = 0;
            m_prev = '0;
            m_ovf  = 1'b0;
            m_q.delete();
            for (int i = 0; i < 4; i++) begin
                m_ticks[i] = 0;
                for (int t = 0; t < 3; t++) m_pend[i][t] = 1'b0;
            end
        end else begin
            m_tick = (m_pre == TD - 1);
            m_pre  = (m_pre + 1) % TD;
            for (int i = 0; i < 4; i++) begin
                m_set[i][0] = btn[i] && !m_prev[i];
                m_set[i][2] = !btn[i] && m_prev[i];
                m_set[i][1] = m_prev[i] && m_tick && (m_ticks[i] == LT - 1);
                if (!m_prev[i]) m_ticks[i] = 0;
                else if (m_tick && m_ticks[i] < LT) m_ticks[i]++;
                for (int t = 0; t < 3; t++) m_clr[i][t] = 1'b0;
            end
            m_granted = 1'b0;
            m_gevt    = '0;
            if (m_q.size() < FD) begin
                for (int i = 0; i < 4; i++) begin
                    for (int t = 0; t < 3; t++) begin
                        if (!m_granted && m_pend[i][t]) begin
                            m_granted   = 1'b1;
                            m_clr[i][t] = 1'b1;
                            m_gevt      = {evtCode(t), 2'(i)};
                        end
                    end
                end
            end
            if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
            if (m_granted) m_q.push_back(m_gevt);
            m_loss = 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int t = 0; t < 3; t++) begin
                    if (m_set[i][t] && m_pend[i][t] && !m_clr[i][t]) m_loss = 1'b1;
                    m_pend[i][t] = (m_pend[i][t] && !m_clr[i][t]) || m_set[i][t];
                end
            end
            m_ovf  = m_loss || (m_ovf && !ovf_clr);
            m_prev = btn;
        end
    endtask

    // Drive one cycle of inputs, then wait for the following falling edge.
    task automatic applyStimulus(input logic [3:0] b, input logic rdy,
                                 input logic clr, input logic rn);
        btn       = b;
        evt_ready = rdy;
        ovf_clr   = clr;
        rst_n     = rn;
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [5:0] actual,
                               input logic [5:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b (valid,evt[3:0],ovf)",
                     name, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", obs(), 6'b0_0000_0);
    endtask

    initial begin
        int         long_cnt;
        int         long_k;
        logic       exp_ovf;
        logic [3:0] seq [$];
        logic [3:0] rb;

        // Single click on button 2, then a simultaneous press/release of buttons 0,1,3.
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[1]  = '{4'b0100, 1'b1, 1'b0, 6'b1_0110_0};
        vecs[2]  = '{4'b0100, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[3]  = '{4'b0100, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[4]  = '{4'b0100, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 6'b1_1010_0};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[8]  = '{4'b1011, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[9]  = '{4'b1011, 1'b1, 1'b0, 6'b1_0100_0};
        vecs[10] = '{4'b1011, 1'b1, 1'b0, 6'b1_0101_0};
        vecs[11] = '{4'b1011, 1'b1, 1'b0, 6'b1_0111_0};
        vecs[12] = '{4'b1011, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 6'b0_0000_0};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 6'b1_1000_0};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 6'b1_1001_0};
        vecs[16] = '{4'b0000, 1'b1, 1'b0, 6'b1_1011_0};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 6'b0_0000_0};

        btn = '0; evt_ready = 1'b0; ovf_clr = 1'b0; rst_n = 1'b0;
        doReset();
        for (int v = 0; v < 18; v++) begin
            applyStimulus(vecs[v].btn, vecs[v].rdy, vecs[v].clr, 1'b1);
            checkOutput($sformatf("vec%0d", v), obs(), vecs[v].exp);
        end

        // Long press on button 1 for 20 cycles.
        long_cnt = 0;
        long_k   = -1;
        for (int k = 0; k < 28; k++) begin
            applyStimulus((k < 20) ? 4'b0010 : 4'b0000, 1'b1, 1'b0, 1'b1);
            if (k == 1)  checkOutput("long_press_press", obs(), 6'b1_0101_0);
            if (k == 21) checkOutput("long_press_release", obs(), 6'b1_1001_0);
            if (evt_valid && evt == 4'b1101) begin
                long_cnt++;
                long_k = k;
            end
        end
        checkOutput("long_count", 6'(long_cnt), 6'd1);
        checkOutput("long_window", {5'd0, (long_k >= 9 && long_k <= 13)}, 6'd1);

        // Backpressure: toggling button 0 fills the FIFO, pending bits, then collides.
        doReset();
        for (int j = 0; j < 8; j++) begin
            applyStimulus((j % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b1);
            exp_ovf = (j >= 6);
            if (j >= 1) checkOutput($sformatf("bp_head%0d", j), obs(), {1'b1, 4'b0100, exp_ovf});
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("ovf_clear", obs(), 6'b1_0100_0);
        seq.delete();
        for (int n = 0; n < 12; n++) begin
            if (evt_valid) seq.push_back(evt);
            applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("drain_count", 6'(seq.size()), 6'd6);
        for (int m = 0; m < seq.size(); m++) begin
            checkOutput($sformatf("drain%0d", m), {1'b1, seq[m], 1'b0},
                        {1'b1, (m % 2 == 0) ? 4'b0100 : 4'b1000, 1'b0});
        end
        checkOutput("drain_empty", obs(), 6'b0_0000_0);

        // A new loss in the same cycle as ovf_clr keeps the flag set.
        for (int j = 0; j < 8; j++) begin
            applyStimulus((j % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, (j == 7), 1'b1);
            if (j == 6) checkOutput("loss_before_clr", obs(), 6'b1_0100_1);
            if (j == 7) checkOutput("clr_with_loss", obs(), 6'b1_0100_1);
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_alone", obs(), 6'b1_0100_0);

        // Reset with three queued events while button 3 is held.
        doReset();
        for (int j = 0; j < 4; j++) applyStimulus(4'b0111, 1'b0, 1'b0, 1'b1);
        checkOutput("queued3", obs(), 6'b1_0100_0);
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_flush", obs(), 6'b0_0000_0);
        seq.delete();
        for (int n = 0; n < 6; n++) begin
            applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1);
            if (evt_valid) seq.push_back(evt);
        end
        checkOutput("post_reset_count", 6'(seq.size()), 6'd1);
        if (seq.size() > 0) checkOutput("post_reset_evt", {1'b1, seq[0], 1'b0}, 6'b1_0111_0);

        // Randomized run against the reference model.
        doReset();
        rb = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 11) == 0) rb[b] = ~rb[b];
            end
            applyStimulus(rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 399) != 0));
            checkOutput("random", obs(), modelOut());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
